// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: 32-cycle shift-add multiply, 32-cycle restoring divide, MTHI/MTLO moves.
// Build option: define MULDIV_DIV_EN to build the divider; otherwise DIV completes at once with errFlag=1.
module hilo_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  operation,
  input  logic        sign,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] outHI,
  output logic [31:0] outLO,
  output logic        busy,
  output logic        done,
  output logic        errFlag
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_DIV = 2'b01, OP_MTHI = 2'b10, OP_MTLO = 2'b11} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic        go_q, go_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opd_q, opd_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        bzero_q, bzero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        a_neg, b_neg, div_en;
  logic [31:0] mag_a, mag_b, quo_fix, rem_fix;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next, prod_fix;

  assign a_neg = sign & A[31];
  assign b_neg = sign & B[31];
  assign mag_a = a_neg ? (~A + 32'd1) : A;
  assign mag_b = b_neg ? (~B + 32'd1) : B;

  // acc holds {partial product, remaining multiplier bits}; each step adds and shifts right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

`ifdef MULDIV_DIV_EN
  logic [32:0] div_win, div_diff;
  assign div_en   = 1'b1;
  // acc holds {remainder, dividend/quotient}; a borrow in div_diff means restore.
  assign div_win  = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_win - {1'b0, opd_q};
  assign div_next = div_diff[32] ? {div_win[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};
`else
  assign div_en   = 1'b0;
  assign div_next = acc_q;
`endif

  assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d   = state_q;
    op_d      = op_q;
    go_d      = go_q;
    cnt_d     = cnt_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (go_q) begin
          // Dispatch cycle after accept: the operands are already latched and converted.
          go_d  = 1'b0;
          cnt_d = 5'd0;
          case (op_q)
            OP_MULT: state_d = S_MUL;
            OP_DIV: begin
              if (!div_en || bzero_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                busy_d  = 1'b0;
              end else begin
                state_d = S_DIV;
              end
            end
            OP_MTHI: begin
              hi_d    = opd_q;
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
            default: begin
              lo_d    = opd_q;
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          endcase
        end else if (start) begin
          go_d      = 1'b1;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          op_d      = op_t'(operation);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = (B == 32'd0);
          case (op_t'(operation))
            OP_MULT: begin
              opd_d = mag_a;
              acc_d = {32'd0, mag_b};
            end
            OP_DIV: begin
              opd_d = mag_b;
              acc_d = {32'd0, mag_a};
            end
            default: opd_d = A;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next : div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (op_q == OP_MULT) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      go_q      <= 1'b0;
      cnt_q     <= 5'd0;
      opd_q     <= 32'd0;
      acc_q     <= 64'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      go_q      <= go_d;
      cnt_q     <= cnt_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign outHI   = hi_q;
  assign outLO   = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign errFlag = err_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: transaction-level reference model compared every cycle,
// plus literal expectations. Honours MULDIV_DIV_EN the same way as the design.
module tb_hilo_muldiv;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  operation = 2'b00;
  logic        sign = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] outHI, outLO;
  logic        busy, done, errFlag;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  hilo_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation), .sign(sign),
    .A(A), .B(B), .outHI(outHI), .outLO(outLO), .busy(busy), .done(done), .errFlag(errFlag)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result of one accepted operation as the architecture defines it.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whi;
    logic        wlo;
    logic        err;
    logic [5:0]  lat;
  } res_t;

  function automatic res_t model_op(input logic [1:0] op, input logic sg,
                                    input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb;
    logic [63:0] p, q, m;
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    r = '0;
    r.lat = 6'd1;
    case (op)
      2'b00: begin
        p = 64'(sa * sb);
        r.hi = p[63:32]; r.lo = p[31:0]; r.whi = 1'b1; r.wlo = 1'b1; r.lat = 6'd34;
      end
      2'b01: begin
        if (b == 32'd0 || !DIV_EN) r.err = 1'b1;
        else begin
          q = 64'(sa / sb);
          m = 64'(sa % sb);
          r.lo = q[31:0]; r.hi = m[31:0]; r.whi = 1'b1; r.wlo = 1'b1; r.lat = 6'd34;
        end
      end
      2'b10: begin r.hi = a; r.whi = 1'b1; end
      default: begin r.lo = a; r.wlo = 1'b1; end
    endcase
    return r;
  endfunction

  // Reference timing: accept when idle, outputs land `lat` edges later, one-cycle done.
  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done, m_err, m_active;
  int          m_left;
  res_t        m_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_active <= 1'b0; m_left <= 0; m_res <= '0;
    end else begin
      if (m_done) m_done <= 1'b0;
      if (m_active) begin
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_busy   <= 1'b0;
          m_err    <= m_res.err;
          if (m_res.whi) m_hi <= m_res.hi;
          if (m_res.wlo) m_lo <= m_res.lo;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (!m_done && start) begin
        m_res    <= model_op(operation, sign, A, B);
        m_left   <= int'(model_op(operation, sign, A, B).lat);
        m_active <= 1'b1;
        m_busy   <= 1'b1;
        m_err    <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("done",    64'(done),    64'(m_done));
      check("busy",    64'(busy),    64'(m_busy));
      check("errFlag", 64'(errFlag), 64'(m_err));
      check("outHI",   64'(outHI),   64'(m_hi));
      check("outLO",   64'(outLO),   64'(m_lo));
    end
  end

  // One operation: pulse start, scramble inputs after accept, optionally poke start while busy,
  // wait (bounded) for done and optionally check literal results and latency.
  task automatic do_op(input string nm, input logic [1:0] op, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic eerr,
                       input int ecyc, input int poke, input logic dstart, input bit lit);
    int cyc;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; operation = op; sign = sg; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; sign = 1'($urandom_range(0, 1));
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      start = (cyc == poke);
      if (cyc == poke) operation = 2'($urandom_range(0, 3));
      @(negedge clk);
      cyc++;
    end
    start = dstart;
    check({nm, "_timeout"}, 64'(cyc < 60), 64'd1);
    if (lit) begin
      check({nm, "_cycle"}, 64'(cyc), 64'(ecyc));
      check({nm, "_hi"},    64'(outHI), 64'(ehi));
      check({nm, "_lo"},    64'(outLO), 64'(elo));
      check({nm, "_err"},   64'(errFlag), 64'(eerr));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    logic [31:0] lo_prev;
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hi",   64'(outHI), 64'd0);
    check("rst_lo",   64'(outLO), 64'd0);
    check("rst_busy", 64'(busy),  64'd0);
    check("rst_done", 64'(done),  64'd0);
    check("rst_err",  64'(errFlag), 64'd0);

    do_op("mult_7x6",   2'b00, 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 34, -1, 1'b0, 1'b1);
    do_op("mult_ffff",  2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, -1, 1'b0, 1'b1);
    do_op("mult_m3x5",  2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, -1, 1'b0, 1'b1);
`ifdef MULDIV_DIV_EN
    do_op("div_m7_2",   2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, -1, 1'b0, 1'b1);
    do_op("div_8_3",    2'b01, 1'b0, 32'd8, 32'd3, 32'd2, 32'd2, 1'b0, 34, -1, 1'b0, 1'b1);
    do_op("div_by0",    2'b01, 1'b0, 32'd99, 32'd0, 32'd2, 32'd2, 1'b1, 1, -1, 1'b0, 1'b1);
    do_op("div_wrap",   2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 1'b0, 34, -1, 1'b0, 1'b1);
    lo_prev = 32'h8000_0000;
`else
    do_op("div_m7_2",   2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1, -1, 1'b0, 1'b1);
    do_op("div_8_3",    2'b01, 1'b0, 32'd8, 32'd3,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1, -1, 1'b0, 1'b1);
    do_op("div_by0",    2'b01, 1'b0, 32'd99, 32'd0,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1, -1, 1'b0, 1'b1);
    do_op("div_wrap",   2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1, -1, 1'b0, 1'b1);
    lo_prev = 32'hFFFF_FFF1;
`endif
    // start held high through the DONE cycle must be ignored.
    do_op("mthi",  2'b10, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, lo_prev, 1'b0, 1, -1, 1'b1, 1'b1);
    do_op("mtlo",  2'b11, 1'b0, 32'h9ABC_DEF0, 32'd0,
          32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1, -1, 1'b0, 1'b1);
    do_op("mult_poke", 2'b00, 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 34, 5, 1'b0, 1'b1);

    // Reset ten cycles into a multiply: operation abandoned, no done pulse.
    @(negedge clk);
    start = 1'b1; operation = 2'b00; sign = 1'b0; A = 32'd7; B = 32'd6;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    #2 reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy),  64'd0);
    check("midrst_done", 64'(done),  64'd0);
    check("midrst_hi",   64'(outHI), 64'd0);
    check("midrst_lo",   64'(outLO), 64'd0);
    do_op("mult_after_rst", 2'b00, 1'b0, 32'd3, 32'd4, 32'h0, 32'hC, 1'b0, 34, -1, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      do_op("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
            32'd0, 32'd0, 1'b0, 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1,
            1'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port operation, input, 2 bits: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-005 SHALL have port sign, input, 1 bit: 1 means signed two's-complement operands, 0 means unsigned; MULT/DIV only.
REQ-006 SHALL have ports A and B, input, 32 bits each: A is multiplicand/dividend/move source; B is multiplier/divisor.
REQ-007 SHALL have ports outHI and outLO, output, 32 bits each: architectural HI/LO registers consumed by the ALU.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after accept until the cycle done is asserted.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO hold the new result.
REQ-010 SHALL have port errFlag, output, 1 bit: valid with done; 1 means divide-by-zero or unsupported op.

Function
REQ-011 SHALL implement an FSM with states IDLE, MUL, DIV, FIX and DONE.
REQ-012 SHALL accept start only in IDLE; accept edge = cycle 0; operands latched at accept; start while busy SHALL be ignored, with no queueing.
REQ-013 MULT SHALL run a radix-2 shift-add for exactly 32 cycles in MUL, then 1 cycle in FIX, then DONE; done high in cycle 34.
REQ-014 DIV SHALL run restoring division for exactly 32 cycles in DIV, then FIX, then DONE; done high in cycle 34.
REQ-015 When sign=1, SHALL convert operands to magnitudes at accept and apply sign correction in FIX.
- Product: negate the 64-bit result if operand signs differ.
- Quotient: negative if signs differ.
- Remainder: takes the sign of the dividend.
REQ-016 MULT SHALL write product[63:32] to outHI and product[31:0] to outLO on the edge entering DONE.
REQ-017 DIV SHALL write the quotient to outLO and the remainder to outHI on the edge entering DONE.
REQ-018 DIV with B=0 SHALL skip DIV/FIX, go to DONE in cycle 1, leave HI/LO unchanged, and set errFlag=1.
REQ-019 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (wrap, no error).
REQ-020 MTHI/MTLO SHALL write A into outHI/outLO respectively, go directly to DONE, and raise done in cycle 1.
REQ-021 DONE SHALL last one cycle, then return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-022 errFlag SHALL equal 0 on every done pulse except REQ-018 and REQ-026; it is held until the next accept.
REQ-023 outHI/outLO SHALL never show partial results; they change only on entry to DONE.

Reset
REQ-024 On reset, SHALL asynchronously force the FSM to IDLE with outHI=0, outLO=0, busy=0, done=0, errFlag=0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation with no done pulse; a start on the first edge after deassertion SHALL be accepted.

Configuration
REQ-026 Macro MULDIV_DIV_EN:
- Defined: DIV is implemented as specified.
- Undefined: no divider datapath is built; DIV goes to DONE in cycle 1 with errFlag=1 and HI/LO unchanged.
- MULT, MTHI and MTLO are identical in both builds.

Verification
REQ-027 The bench SHALL cover: MULT, sign=0, A=7, B=6 -> done at cycle 34, outHI=0x00000000, outLO=0x0000002A, errFlag=0.
REQ-028 The bench SHALL cover: MULT, sign=0, A=B=0xFFFFFFFF -> outHI=0xFFFFFFFE, outLO=0x00000001; and MULT, sign=1, A=-3, B=5 -> outHI=0xFFFFFFFF, outLO=0xFFFFFFF1.
REQ-029 The bench SHALL cover: DIV, sign=1, A=-7, B=2 -> outLO=0xFFFFFFFD, outHI=0xFFFFFFFF at cycle 34; and DIV, sign=0, A=8, B=3 -> outLO=2, outHI=2.
REQ-030 The bench SHALL cover: DIV with B=0 after the prior result -> done at cycle 1, errFlag=1, HI/LO unchanged; with MULDIV_DIV_EN undefined, any DIV -> the same response.
REQ-031 The bench SHALL cover: MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 -> each done at cycle 1, outHI=0x12345678, outLO=0x9ABCDEF0.
REQ-032 The bench SHALL cover: MULT started, then reset at cycle 10 -> busy=0, outHI=outLO=0, no done pulse; a second start pulsed at cycle 5 of a running MULT -> ignored, single done at cycle 34.
